// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
//   seq_state_t : detector FSM state (EMPTY / FILLING / ARMED)
//   fill_width  : bit width needed for a fill counter spanning 0..len
package seq_det_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } seq_state_t;

    // Width of a counter that must hold every value 0..len inclusive.
    function automatic int fill_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and soft clear.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (highest priority)
//   clr   : synchronous clear to zero (beats inc)
//   inc   : advance by one; held at all-ones once saturated
//   q     : current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector. Shifts one qualified bit per clock into a
// PATTERN_LEN-bit window and pulses match when the window equals PATTERN
// while holding PATTERN_LEN bits received since the last reset/clear
// (or since the last match when overlap is disabled).
//   clk         : rising-edge clock, shared with the upstream DFF
//   rst_n       : synchronous active-low reset
//   bit_in      : serial data from the upstream DFF Q
//   bit_valid   : qualifies bit_in on this edge
//   clear       : soft clear of fill, match and match_count (window kept)
//   match       : registered one-cycle pulse per detected pattern
//   match_count : saturating count of matches
//   armed       : window holds PATTERN_LEN valid bits
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     OVERLAP     = 1,
    parameter int                     CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int                FILL_W = fill_width(PATTERN_LEN);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PATTERN_LEN);

    // The shift expression below needs at least two window bits.
    if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
        $error("seq_detector: PATTERN_LEN must be in 2..16");
    end

    seq_state_t             state, next_state;
    logic [PATTERN_LEN-1:0] win, next_win, shift_win;
    logic [FILL_W-1:0]      fill, next_fill, shift_fill;
    logic                   take;     // a bit is actually consumed this edge
    logic                   hit;      // pattern completes on this edge
    logic                   restart;  // non-overlapping mode drops the fill

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            win   <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            state <= next_state;
            win   <= next_win;
            fill  <= next_fill;
            // hit already excludes clear, so clear forces the pulse low.
            match <= hit;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        shift_win  = {win[PATTERN_LEN-2:0], bit_in};
        shift_fill = (fill == FULL) ? FULL : fill + 1'b1;

        // A bit arriving together with clear is discarded.
        take    = bit_valid && !clear;
        // Compare on the post-shift window so a match reports one edge
        // after the completing bit, not two.
        hit     = take && (shift_win == PATTERN) && (shift_fill == FULL);
        restart = hit && (OVERLAP == 0);

        // Window contents survive clear and restart; only fill gates
        // whether they can match again.
        next_win = take ? shift_win : win;

        next_fill = fill;
        if (clear) begin
            next_fill = '0;
        end else if (take) begin
            next_fill = restart ? '0 : shift_fill;
        end

        next_state = state;
        case (state)
            EMPTY: begin
                if (take) next_state = FILLING;
            end
            FILLING: begin
                if (clear) begin
                    next_state = EMPTY;
                end else if (take && (shift_fill == FULL)) begin
                    next_state = restart ? EMPTY : ARMED;
                end
            end
            ARMED: begin
                if (clear || restart) next_state = EMPTY;
            end
            default: next_state = EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        armed = (state == ARMED);
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clear),
        .inc  (hit),
        .q    (match_count)
    );

endmodule

// File: tb/tb_seq_detector.sv
module tb_seq_detector;

    logic clk;
    logic rst_n;
    logic bit_in;
    logic bit_valid;
    logic clear;

    logic       m_a, m_b, m_c;
    logic [7:0] c_a, c_b;
    logic [1:0] c_c;
    logic       a_a, a_b, a_c;

    int total = 0;
    int bad   = 0;

    // Default: overlapping, 8-bit count.
    seq_detector dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .match(m_a), .match_count(c_a), .armed(a_a)
    );

    // Non-overlapping variant.
    seq_detector #(.OVERLAP(0)) dut_no (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .match(m_b), .match_count(c_b), .armed(a_b)
    );

    // Narrow counter for saturation.
    seq_detector #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .match(m_c), .match_count(c_c), .armed(a_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r, v, b, c;
        logic       em;
        logic [7:0] ec;
        logic       ea;
        logic       em0;
        logic [7:0] ec0;
        logic       ea0;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic r, v, b, c,
                                input logic em, input logic [7:0] ec, input logic ea,
                                input logic em0, input logic [7:0] ec0, input logic ea0);
        vec_t t;
        t.r = r; t.v = v; t.b = b; t.c = c;
        t.em = em; t.ec = ec; t.ea = ea;
        t.em0 = em0; t.ec0 = ec0; t.ea0 = ea0;
        tv.push_back(t);
    endfunction

    task automatic drive(input logic r, input logic v, input logic b, input logic c);
        rst_n = r; bit_valid = v; bit_in = b; clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        int pulses;
        int nm;
        logic sat_bits [$];
        logic exp_m;

        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;

        // Reset with random data on the inputs.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 1'b0);
            chk($sformatf("rst%0d.match", i), m_a, 0);
            chk($sformatf("rst%0d.count", i), c_a, 0);
            chk($sformatf("rst%0d.armed", i), a_a, 0);
        end

        // Basic match and overlap stream 1,0,1,1,0,1,1.
        add(1,1,1,0, 0,0,0, 0,0,0);
        add(1,1,0,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 1,1,1, 1,1,0);
        add(1,1,0,0, 0,1,1, 0,1,0);
        add(1,1,1,0, 0,1,1, 0,1,0);
        add(1,1,1,0, 1,2,1, 0,1,0);
        // Invalid cycle: bit ignored, pulse drops, count holds.
        add(1,0,1,0, 0,2,1, 0,1,0);
        // Clear.
        add(1,0,0,1, 0,0,0, 0,0,0);
        // Valid gaps: 1,0,1,1 with three idle cycles between bits.
        add(1,1,1,0, 0,0,0, 0,0,0);
        for (int g = 0; g < 3; g++) add(1,0,0,0, 0,0,0, 0,0,0);
        add(1,1,0,0, 0,0,0, 0,0,0);
        for (int g = 0; g < 3; g++) add(1,0,0,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 0,0,0, 0,0,0);
        for (int g = 0; g < 3; g++) add(1,0,0,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 1,1,1, 1,1,0);
        add(1,0,0,0, 0,1,1, 0,1,0);
        // Clear mid-pattern: 1,0,1, clear+valid 1, then 1 -> window reads
        // 1011 but fill is only 1, so no match.
        add(1,0,0,1, 0,0,0, 0,0,0);
        add(1,1,1,0, 0,0,0, 0,0,0);
        add(1,1,0,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 0,0,0, 0,0,0);
        add(1,1,1,1, 0,0,0, 0,0,0);
        add(1,1,1,0, 0,0,0, 0,0,0);
        // Reset mid-pattern, same shape.
        add(0,0,0,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 0,0,0, 0,0,0);
        add(1,1,0,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 0,0,0, 0,0,0);
        add(0,1,1,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 0,0,0, 0,0,0);
        // Fresh bits after reset do complete 1,0,1,1.
        add(1,1,0,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 0,0,0, 0,0,0);
        add(1,1,1,0, 1,1,1, 1,1,0);

        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].v, tv[i].b, tv[i].c);
            chk($sformatf("v%0d.match", i),    m_a, tv[i].em);
            chk($sformatf("v%0d.count", i),    c_a, tv[i].ec);
            chk($sformatf("v%0d.armed", i),    a_a, tv[i].ea);
            chk($sformatf("v%0d.match_no", i), m_b, tv[i].em0);
            chk($sformatf("v%0d.count_no", i), c_b, tv[i].ec0);
            chk($sformatf("v%0d.armed_no", i), a_b, tv[i].ea0);
        end

        // Saturation on the 2-bit counter: 1,0,1,1 then four x 0,1,1.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        sat_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            sat_bits.push_back(1'b0);
            sat_bits.push_back(1'b1);
            sat_bits.push_back(1'b1);
        end
        pulses = 0;
        nm = 0;
        foreach (sat_bits[i]) begin
            drive(1'b1, 1'b1, sat_bits[i], 1'b0);
            exp_m = (i >= 3) && ((i - 3) % 3 == 0);
            if (exp_m) nm++;
            if (m_c) pulses++;
            chk($sformatf("sat%0d.match", i), m_c, exp_m);
            chk($sformatf("sat%0d.count", i), c_c, (nm > 3) ? 3 : nm);
        end
        chk("sat.pulses", pulses, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
# seq_detector

Serial pattern detector that consumes the registered single-bit stream produced by the team's D flip-flop stage. It samples one bit per qualified clock and keeps a sliding window of the last `PATTERN_LEN` bits. On each window match it emits a one-cycle `match` pulse and advances a saturating match counter. It is the first consumer stage downstream of the DFF and operates in that stage's clock domain.

## Interface
Parameters:
- `PATTERN_LEN`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011: target pattern, MSB = oldest bit received.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = window restarts after a match.
- `CNT_W`, 8: width of `match_count`.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock, same clock as the upstream DFF.
- `rst_n`  in  1  synchronous active-low reset; sampled only on `clk` rise.
- `bit_in`  in  1  serial data; connects to the upstream DFF `Q`.
- `bit_valid`  in  1  qualifies `bit_in` on this edge; when low, `bit_in` is ignored.
- `clear`  in  1  synchronous soft clear of window fill, `match` and `match_count`.
- `match`  out  1  one-cycle registered pulse per detected pattern.
- `match_count`  out  CNT_W  saturating count of matches.
- `armed`  out  1  high when the window holds `PATTERN_LEN` valid bits (state ARMED).

## Operation
- Window register `win[PATTERN_LEN-1:0]`.
  - On a valid cycle: `win <= {win[PATTERN_LEN-2:0], bit_in}`.
- Fill counter `fill`, range 0..PATTERN_LEN.
  - On a valid cycle: `fill <= min(fill+1, PATTERN_LEN)`.
- FSM states, derived from `fill`:
  - EMPTY: `fill == 0`.
  - FILLING: `0 < fill < PATTERN_LEN`.
  - ARMED: `fill == PATTERN_LEN`.
- FSM transitions:
  - EMPTY -> FILLING on a valid bit.
  - FILLING -> ARMED when the valid bit brings the next fill to `PATTERN_LEN`. With `PATTERN_LEN == 1` excluded, there is no direct EMPTY -> ARMED.
  - ARMED -> EMPTY on a match when `OVERLAP == 0`, or on `clear`.
  - Any state -> EMPTY on `clear`.
- Match condition, evaluated on a valid cycle using the *next* window and fill: `next_win == PATTERN` and `next_fill == PATTERN_LEN`.
- When the match condition holds:
  - `match <= 1`.
  - `match_count <= match_count + 1`, saturating at 2^CNT_W−1. At saturation `match` still pulses.
  - If `OVERLAP == 0`, `fill <= 0`. The window contents are kept but are not matchable until the fill reaches full again.
- Otherwise `match <= 0`. `match` is never high for two consecutive cycles unless two consecutive valid bits both complete a match.
- Priority, highest first:
  1. `rst_n` low: `win`, `fill`, `match`, `match_count` all 0; state EMPTY.
  2. `clear` high: `fill`, `match`, `match_count` set to 0; `win` unchanged. A simultaneous valid bit is discarded.
  3. Normal shift and compare.
- Reset or clear in the middle of a partial pattern drops that pattern entirely. Bits received before the event never contribute to a later match.

## Timing
- Reset values: `match` = 0, `match_count` = 0, `armed` = 0.
- Latency: a bit valid at edge N that completes a pattern produces `match` = 1 for the cycle following edge N. `match_count` updates at the same edge.
- `armed` is a registered output and reflects `fill` after the edge.
- No back-pressure: `bit_valid` may be held high continuously, or toggled freely with any gap length.
- Inputs are sampled on the `clk` rise only. Upstream `Q` changes just after the edge, so it is stable at the next edge.

## Structure
- Package `seq_det_pkg` holds:
  - the state enum `seq_state_t` {EMPTY, FILLING, ARMED};
  - a localparam helper computing the fill counter width, `$clog2(PATTERN_LEN+1)`.
- Sub-module `sat_counter`, parameterised by width, with `clk`, `rst_n`, `clr`, `inc` and `q` ports. It implements the saturating `match_count` and is reusable elsewhere.
- Everything else (window, fill, FSM, compare) lives in `seq_detector`.

## Test plan
Defaults: `PATTERN` = 1011, `PATTERN_LEN` = 4, with a 10 ns clock.
- **Reset:** hold `rst_n` = 0 for 2 edges with random `bit_in`/`bit_valid` -> `match` = 0, `match_count` = 0, `armed` = 0 throughout.
- **Basic match:** valid bits 1,0,1,1 on consecutive edges -> `armed` = 1 after the 4th edge; `match` = 1 for exactly one cycle after the 4th edge; `match_count` = 1.
- **Overlap:** stream 1,0,1,1,0,1,1.
  - `OVERLAP` = 1 -> `match` after bits 4 and 7; `match_count` = 2.
  - `OVERLAP` = 0 -> `match` after bit 4 only; `match_count` = 1.
- **Valid gaps:** same 1,0,1,1 stream with 3 `bit_valid` = 0 cycles between each bit, driving `bit_in` = 0 on the gap cycles -> a single `match` one cycle after the last valid bit; `match_count` = 1.
- **Saturation:** with `CNT_W` = 2, apply 5 overlapping matches -> `match_count` reads 1,2,3,3,3 and `match` pulses 5 times.
- **Clear and mid-operation reset:**
  - Bits 1,0,1, then `clear` together with valid bit 1, then bit 1 -> no `match`; `match_count` = 0.
  - Repeat with `rst_n` pulsed low instead of `clear` -> same result.
